// File: rtl/pipe_arb.sv
// Round-robin arbiter that feeds one operand set per cycle to an external 3-stage
// datapath and tags each result with its requester. Optional macro PIPE_ARB_CNT_EN adds issue_cnt.
`timescale 1ns/1ps

module pipe_arb #(
   parameter int N    = 10,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*N-1:0] req_c,
   input  logic [NREQ*N-1:0] req_d,
   output logic [N-1:0]      pipe_a,
   output logic [N-1:0]      pipe_b,
   output logic [N-1:0]      pipe_c,
   output logic [N-1:0]      pipe_d,
   output logic              pipe_en,
   input  logic [N-1:0]      pipe_f,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N-1:0]      res_data,
   output logic [1:0]        res_tag,
   output logic              busy
`ifdef PIPE_ARB_CNT_EN
   ,
   output logic [15:0]       issue_cnt
`endif
);

   logic [1:0] ptr;
   logic [1:0] gnt_idx;
   logic [1:0] cand;
   logic       gnt_found;
   logic       grant;

   logic       v1, v2, v3;
   logic [1:0] t1, t2, t3;

   // The whole pipe advances together; it only stops when a finished result is refused.
   assign pipe_en = ~(v3 & ~res_ready);
   assign grant   = pipe_en & gnt_found;

   // Search from ptr upward with 2-bit wrap; the first asserted requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = ptr;
      cand      = ptr;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr + 2'(k);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      pipe_a    = '0;
      pipe_b    = '0;
      pipe_c    = '0;
      pipe_d    = '0;
      if (grant) begin
         req_ready[gnt_idx] = 1'b1;
         pipe_a = req_a[gnt_idx*N +: N];
         pipe_b = req_b[gnt_idx*N +: N];
         pipe_c = req_c[gnt_idx*N +: N];
         pipe_d = req_d[gnt_idx*N +: N];
      end
   end

   // Valid/tag slots shadow the datapath stages and freeze with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         t1  <= 2'd0;
         t2  <= 2'd0;
         t3  <= 2'd0;
         ptr <= 2'd0;
      end else if (pipe_en) begin
         v1 <= grant;
         t1 <= gnt_idx;
         v2 <= v1;
         t2 <= t1;
         v3 <= v2;
         t3 <= t2;
         if (grant) begin
            ptr <= gnt_idx + 2'd1;
         end
      end
   end

   assign res_valid = v3;
   assign res_tag   = t3;
   assign res_data  = pipe_f;
   assign busy      = v1 | v2 | v3;

`ifdef PIPE_ARB_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= 16'd0;
      end else if (grant) begin
         issue_cnt <= issue_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/pipe_arb.md
PIPE_ARB -- requirements
Module: pipe_arb

Interface
REQ-001 The block SHALL have parameter N, default 10, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter NREQ, fixed at 4, giving the number of requesters; tag width is 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operand-set valid.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a, req_b, req_c, req_d  input  NREQ*N each  flattened operands; requester i occupies bits [i*N +: N].
REQ-008 pipe_a, pipe_b, pipe_c, pipe_d  output  N each  operands driven to the 3-stage datapath, F = (A+B+C-D)*D.
REQ-009 pipe_en  output  1  datapath stage-advance enable.
REQ-010 pipe_f  input  N  datapath stage-3 result.
REQ-011 res_valid  output  1  result valid.
REQ-012 res_ready  input  1  result consumer accept.
REQ-013 res_data  output  N  result; equals pipe_f.
REQ-014 res_tag  output  2  index of the requester owning res_data.
REQ-015 busy  output  1  high when any in-flight slot is valid.

Function
REQ-016 pipe_en SHALL equal NOT(v3 AND NOT res_ready), where v1..v3 are the in-flight valid bits aligned to datapath stages 1..3.
REQ-017 While pipe_en is high, the block SHALL grant exactly one asserted req_valid, chosen round-robin from pointer ptr upward, wrapping 3->0.
REQ-018 req_ready[i] SHALL be high only for the granted i, and only while pipe_en is high; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-019 pipe_a..pipe_d SHALL combinationally mux the granted requester's operands, and SHALL be 0 when no grant is made.
REQ-020 On each pipe_en cycle: v1<=transfer, t1<=granted index, v2<=v1, t2<=t1, v3<=v2, t3<=t2; when pipe_en is low, all slots SHALL hold.
REQ-021 After a grant to i, ptr SHALL become (i+1) mod 4; ptr SHALL hold when there is no grant.
REQ-022 Latency from transfer to res_valid SHALL be exactly 3 pipe_en cycles; with no stall, the result appears 3 clk cycles after the transfer edge.
REQ-023 res_valid SHALL equal v3 and res_tag SHALL equal t3; res_valid SHALL hold its value and res_data/res_tag SHALL stay stable while res_ready is low.
REQ-024 Throughput SHALL be one issue per cycle when no stall occurs; a cycle with no requests SHALL insert a bubble (v1=0).
REQ-025 The block SHALL perform no arithmetic itself; width handling (truncation mod 2^N) is owned by the datapath.
REQ-026 When all four requesters assert continuously, grants SHALL rotate 0,1,2,3,0,... starting from ptr.
REQ-027 A requester that drops req_valid while not granted SHALL lose no state; no request queueing is performed.

Reset
REQ-028 On rst, v1..v3, t1..t3 and ptr SHALL clear to 0 immediately, so res_valid=0, busy=0, pipe_en=1, and req_ready follows the REQ-017 grant from ptr=0.
REQ-029 Reset mid-operation SHALL discard all in-flight results; no res_valid SHALL appear for transfers accepted before reset.

Configuration
REQ-030 With macro PIPE_ARB_CNT_EN defined, the block SHALL add output issue_cnt [15:0], reset to 0, incremented on every transfer and wrapping from 0xFFFF to 0.
REQ-031 Without PIPE_ARB_CNT_EN, the issue_cnt port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-032 Single issue: requester 0 presents A=1, B=2, C=5, D=3, res_ready=1 -> res_valid 3 cycles later, res_data=15, res_tag=0.
REQ-033 Round-robin: all four requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0, and res_tag follows the same order 3 cycles later.
REQ-034 Stall: res_ready=0 while v3=1 -> pipe_en=0, req_ready=0, slots frozen; res_ready=1 -> the stream resumes with no loss or duplication.
REQ-035 Bubbles: requests on cycles 0 and 2 only -> res_valid high on cycles 3 and 5, low on cycle 4.
REQ-036 Reset mid-flight: 2 results in flight, rst pulse -> res_valid=0 and busy=0 immediately, and no stale result afterwards.
REQ-037 PIPE_ARB_CNT_EN defined: issue_cnt preloaded via 65535 transfers, one more transfer -> issue_cnt wraps to 0.
